signal_timestamper: RTL

- Downstream consumer of the signal generator output: timestamps each active edge of an event input (normally SignalGenerator_EvtOut looped back or an external pad) against ClockTime.
- Delay-compensates each timestamp, buffers it in a 4-entry FIFO, and raises an interrupt.
- Software drains the FIFO over AXI4-Lite (16-bit address), in the same register style as the other TimeCard cores.

---
 rtl/signal_timestamper_pkg.sv | 33 +++
 rtl/signal_timestamper_fifo.sv | 57 +++++
 rtl/signal_timestamper.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/signal_timestamper_pkg.sv
// Shared definitions for the signal timestamper: register map, AXI responses
// and the timestamp record carried through the compensation pipeline and FIFO.
package signal_timestamper_pkg;

  localparam logic [15:0] ControlAddr_Con         = 16'h0000;
  localparam logic [15:0] StatusAddr_Con          = 16'h0004;
  localparam logic [15:0] IrqMaskAddr_Con         = 16'h0008;
  localparam logic [15:0] FillLevelAddr_Con       = 16'h000C;
  localparam logic [15:0] CableDelayAddr_Con      = 16'h0010;
  localparam logic [15:0] EventCountAddr_Con      = 16'h0014;
  localparam logic [15:0] TimestampNsAddr_Con     = 16'h0020;
  localparam logic [15:0] TimestampSecondAddr_Con = 16'h0024;

  localparam logic [31:0] NanosPerSecond_Con = 32'd1_000_000_000;

  localparam logic [1:0] RespOkay_Con   = 2'b00;
  localparam logic [1:0] RespSlvErr_Con = 2'b10;

  typedef struct packed {
    logic [31:0] second;
    logic [31:0] nanosecond;
  } Timestamp_Type;

  function automatic logic isMappedAddr(input logic [15:0] addr);
    case (addr)
      ControlAddr_Con, StatusAddr_Con, IrqMaskAddr_Con, FillLevelAddr_Con,
      CableDelayAddr_Con, EventCountAddr_Con, TimestampNsAddr_Con,
      TimestampSecondAddr_Con: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/signal_timestamper_fifo.sv
// Synchronous timestamp FIFO; a push on a full FIFO succeeds only when a pop
// frees a slot in the same cycle.
module signal_timestamper_fifo
  import signal_timestamper_pkg::*;
#(
  parameter  int FifoDepth_Gen  = 4,
  localparam int AddrWidth_Con  = $clog2(FifoDepth_Gen),
  localparam int LevelWidth_Con = AddrWidth_Con + 1
)(
  input  logic                      SysClk_ClkIn,
  input  logic                      SysRstN_RstIn,
  input  logic                      Push_ValIn,
  input  Timestamp_Type             Push_DatIn,
  input  logic                      Pop_ValIn,
  output Timestamp_Type             Head_DatOut,
  output logic                      Full_DatOut,
  output logic                      Empty_DatOut,
  output logic [LevelWidth_Con-1:0] FillLevel_DatOut
);

  Timestamp_Type             mem [FifoDepth_Gen];
  logic [AddrWidth_Con-1:0]  wrPtr;
  logic [AddrWidth_Con-1:0]  rdPtr;
  logic [LevelWidth_Con-1:0] count;
  logic                      doPush;
  logic                      doPop;

  assign Empty_DatOut     = (count == '0);
  assign Full_DatOut      = (count == LevelWidth_Con'(FifoDepth_Gen));
  assign doPop            = Pop_ValIn & ~Empty_DatOut;
  assign doPush           = Push_ValIn & (~Full_DatOut | doPop);
  assign Head_DatOut      = mem[rdPtr];
  assign FillLevel_DatOut = count;

  // NOTE: storage is deliberately not reset; the pointers and count alone say which slots are valid.
  always_ff @(posedge SysClk_ClkIn) begin
    if (doPush) mem[wrPtr] <= Push_DatIn;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AddrWidth_Con'(1);
      if (doPop)  rdPtr <= rdPtr + AddrWidth_Con'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + LevelWidth_Con'(1);
        2'b01:   count <= count - LevelWidth_Con'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/signal_timestamper.sv
// Timestamps active edges of an asynchronous event input against ClockTime,
// removes the input path delay and queues the results for AXI4-Lite readout.
module signal_timestamper
  import signal_timestamper_pkg::*;
#(
  parameter int    ClockPeriod_Gen   = 20,
  parameter int    InputDelay_Gen    = 0,
  parameter string InputPolarity_Gen = "true",
  parameter int    FifoDepth_Gen     = 4
)(
  input  logic        SysClk_ClkIn,
  input  logic        SysRstN_RstIn,
  input  logic [31:0] ClockTime_Second_DatIn,
  input  logic [31:0] ClockTime_Nanosecond_DatIn,
  input  logic        ClockTime_TimeJump_DatIn,
  input  logic        ClockTime_ValIn,
  input  logic        SignalTimestamper_EvtIn,
  output logic        Irq_EvtOut,
  input  logic        AxiWriteAddrValid_ValIn,
  output logic        AxiWriteAddrReady_RdyOut,
  input  logic [15:0] AxiWriteAddrAddress_AdrIn,
  input  logic [2:0]  AxiWriteAddrProt_DatIn,
  input  logic        AxiWriteDataValid_ValIn,
  output logic        AxiWriteDataReady_RdyOut,
  input  logic [31:0] AxiWriteDataData_DatIn,
  input  logic [3:0]  AxiWriteDataStrobe_DatIn,
  output logic        AxiWriteRespValid_ValOut,
  input  logic        AxiWriteRespReady_RdyIn,
  output logic [1:0]  AxiWriteRespResponse_DatOut,
  input  logic        AxiReadAddrValid_ValIn,
  output logic        AxiReadAddrReady_RdyOut,
  input  logic [15:0] AxiReadAddrAddress_AdrIn,
  input  logic [2:0]  AxiReadAddrProt_DatIn,
  output logic        AxiReadDataValid_ValOut,
  input  logic        AxiReadDataReady_RdyIn,
  output logic [1:0]  AxiReadDataResponse_DatOut,
  output logic [31:0] AxiReadDataData_DatOut
);

  localparam bit          RisingActive_Con = (InputPolarity_Gen == "true");
  // Synchroniser plus edge-detect flops add three clock periods of latency.
  localparam logic [31:0] FixedDelay_Con   = 32'(InputDelay_Gen + 3 * ClockPeriod_Gen);
  localparam int          LevelWidth_Con   = $clog2(FifoDepth_Gen) + 1;

  logic        enable, overflow, jump;
  logic [2:0]  irqMask;
  logic [23:0] cableDelay;
  logic [31:0] eventCount;

  logic [2:0]  evtShift;
  logic        detect, captureOk, jumpEvent;

  logic          s1Valid, s2Valid, s3Valid, s2NoBorrow;
  Timestamp_Type s1Time, s3Time;
  logic [31:0]   s1Sub, s2Second, s2SecondDec, s2NsDirect, s2NsWrapped;

  Timestamp_Type             fifoHead;
  logic                      fifoFull, fifoEmpty, fifoPop, pushDropped;
  logic [LevelWidth_Con-1:0] fifoLevel;

  logic        wrReady, wrHandshake, arHandshake;
  logic [31:0] readMux;
  logic        unusedInputs;

  assign unusedInputs = ^{AxiWriteAddrProt_DatIn, AxiReadAddrProt_DatIn,
                          AxiWriteDataData_DatIn[31:24], AxiWriteDataStrobe_DatIn[3]};

  // evtShift[1:0] is the synchroniser, evtShift[2] the edge-detect history.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) evtShift <= '0;
    else                evtShift <= {evtShift[1:0], SignalTimestamper_EvtIn};
  end

  assign detect    = RisingActive_Con ? (evtShift[1] & ~evtShift[2]) : (~evtShift[1] & evtShift[2]);
  assign captureOk = detect & enable & ClockTime_ValIn & ~ClockTime_TimeJump_DatIn;
  assign jumpEvent = detect & enable & ClockTime_ValIn & ClockTime_TimeJump_DatIn;

  // Capture, then precompute both borrow outcomes, then select.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      s1Valid <= 1'b0; s1Time <= '0; s1Sub <= '0;
      s2Valid <= 1'b0; s2NoBorrow <= 1'b0; s2Second <= '0; s2SecondDec <= '0;
      s2NsDirect <= '0; s2NsWrapped <= '0;
      s3Valid <= 1'b0; s3Time <= '0;
    end else begin
      s1Valid <= captureOk;
      if (captureOk) begin
        s1Time <= '{second: ClockTime_Second_DatIn, nanosecond: ClockTime_Nanosecond_DatIn};
        s1Sub  <= FixedDelay_Con + {8'h00, cableDelay};
      end
      s2Valid     <= s1Valid;
      s2NoBorrow  <= (s1Time.nanosecond >= s1Sub);
      s2Second    <= s1Time.second;
      s2SecondDec <= s1Time.second - 32'd1;
      s2NsDirect  <= s1Time.nanosecond - s1Sub;
      s2NsWrapped <= s1Time.nanosecond + NanosPerSecond_Con - s1Sub;
      s3Valid     <= s2Valid;
      s3Time      <= s2NoBorrow ? '{second: s2Second, nanosecond: s2NsDirect}
                                : '{second: s2SecondDec, nanosecond: s2NsWrapped};
    end
  end

  assign fifoPop     = arHandshake & (AxiReadAddrAddress_AdrIn == TimestampSecondAddr_Con) & ~fifoEmpty;
  assign pushDropped = s3Valid & fifoFull & ~fifoPop;

  signal_timestamper_fifo #(.FifoDepth_Gen(FifoDepth_Gen)) fifoInst (
    .SysClk_ClkIn     (SysClk_ClkIn),
    .SysRstN_RstIn    (SysRstN_RstIn),
    .Push_ValIn       (s3Valid),
    .Push_DatIn       (s3Time),
    .Pop_ValIn        (fifoPop),
    .Head_DatOut      (fifoHead),
    .Full_DatOut      (fifoFull),
    .Empty_DatOut     (fifoEmpty),
    .FillLevel_DatOut (fifoLevel)
  );

  assign AxiWriteAddrReady_RdyOut = wrReady;
  assign AxiWriteDataReady_RdyOut = wrReady;
  assign wrHandshake = wrReady & AxiWriteAddrValid_ValIn & AxiWriteDataValid_ValIn;
  assign arHandshake = AxiReadAddrReady_RdyOut & AxiReadAddrValid_ValIn;

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      wrReady <= 1'b0;
      AxiWriteRespValid_ValOut    <= 1'b0;
      AxiWriteRespResponse_DatOut <= RespOkay_Con;
      enable <= 1'b0; overflow <= 1'b0; jump <= 1'b0;
      irqMask <= '0; cableDelay <= '0; eventCount <= '0;
      Irq_EvtOut <= 1'b0;
    end else begin
      wrReady <= ~wrReady & AxiWriteAddrValid_ValIn & AxiWriteDataValid_ValIn & ~AxiWriteRespValid_ValOut;
      if (wrHandshake) begin
        AxiWriteRespValid_ValOut    <= 1'b1;
        AxiWriteRespResponse_DatOut <= isMappedAddr(AxiWriteAddrAddress_AdrIn) ? RespOkay_Con : RespSlvErr_Con;
      end else if (AxiWriteRespReady_RdyIn) begin
        AxiWriteRespValid_ValOut <= 1'b0;
      end

      if (wrHandshake && AxiWriteDataStrobe_DatIn[0]) begin
        if (AxiWriteAddrAddress_AdrIn == ControlAddr_Con) enable  <= AxiWriteDataData_DatIn[0];
        if (AxiWriteAddrAddress_AdrIn == IrqMaskAddr_Con) irqMask <= AxiWriteDataData_DatIn[2:0];
      end
      if (wrHandshake && AxiWriteAddrAddress_AdrIn == CableDelayAddr_Con) begin
        for (int b = 0; b < 3; b++)
          if (AxiWriteDataStrobe_DatIn[b]) cableDelay[8*b +: 8] <= AxiWriteDataData_DatIn[8*b +: 8];
      end

      // Sticky flags: a new set event wins over a simultaneous write-one-to-clear.
      if (wrHandshake && AxiWriteAddrAddress_AdrIn == StatusAddr_Con && AxiWriteDataStrobe_DatIn[0]) begin
        overflow <= (overflow & ~AxiWriteDataData_DatIn[1]) | pushDropped;
        jump     <= (jump & ~AxiWriteDataData_DatIn[2]) | jumpEvent;
      end else begin
        overflow <= overflow | pushDropped;
        jump     <= jump | jumpEvent;
      end

      if (s3Valid) eventCount <= eventCount + 32'd1;
      Irq_EvtOut <= |({jump, overflow, ~fifoEmpty} & irqMask);
    end
  end

  // NOTE: default first so every path assigns readMux and no latch is inferred.
  always_comb begin
    readMux = '0;
    case (AxiReadAddrAddress_AdrIn)
      ControlAddr_Con:         readMux = {31'd0, enable};
      StatusAddr_Con:          readMux = {29'd0, jump, overflow, ~fifoEmpty};
      IrqMaskAddr_Con:         readMux = {29'd0, irqMask};
      FillLevelAddr_Con:       readMux = 32'(fifoLevel);
      CableDelayAddr_Con:      readMux = {8'd0, cableDelay};
      EventCountAddr_Con:      readMux = eventCount;
      TimestampNsAddr_Con:     readMux = fifoEmpty ? 32'd0 : fifoHead.nanosecond;
      TimestampSecondAddr_Con: readMux = fifoEmpty ? 32'd0 : fifoHead.second;
      default:                 readMux = '0;
    endcase
  end

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      AxiReadAddrReady_RdyOut    <= 1'b0;
      AxiReadDataValid_ValOut    <= 1'b0;
      AxiReadDataResponse_DatOut <= RespOkay_Con;
      AxiReadDataData_DatOut     <= '0;
    end else begin
      AxiReadAddrReady_RdyOut <= ~AxiReadAddrReady_RdyOut & AxiReadAddrValid_ValIn & ~AxiReadDataValid_ValOut;
      if (arHandshake) begin
        AxiReadDataValid_ValOut    <= 1'b1;
        AxiReadDataData_DatOut     <= readMux;
        AxiReadDataResponse_DatOut <= isMappedAddr(AxiReadAddrAddress_AdrIn) ? RespOkay_Con : RespSlvErr_Con;
      end else if (AxiReadDataReady_RdyIn) begin
        AxiReadDataValid_ValOut <= 1'b0;
      end
    end
  end

endmodule
